// File: rtl/mux_n_arb.sv
// N-channel selector for the calc datapath: direct (addr) or round-robin scan selection
// into a single registered valid/ready output stage carrying the word and its channel index.
module mux_n_arb #(
   parameter int WIDTH = 8,
   parameter int CH    = 8,
   parameter int SELW  = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                mode,
   input  logic [SELW-1:0]     addr,
   input  logic [CH*WIDTH-1:0] in_data,
   input  logic [CH-1:0]       in_valid,
   output logic [CH-1:0]       in_ready,
   output logic [WIDTH-1:0]    out_data,
   output logic [SELW-1:0]     out_ch,
   output logic                out_valid,
   input  logic                out_ready
);

   if (CH < 2 || CH > 64) begin : g_bad_ch
      $error("mux_n_arb: CH must be in 2..64");
   end
   if (SELW < $clog2(CH)) begin : g_bad_selw
      $error("mux_n_arb: SELW too narrow for CH");
   end

   logic [SELW-1:0]  ptr;
   logic [SELW-1:0]  ptr_next;
   logic             slot_free;
   logic             dir_vld;
   logic             scan_vld;
   logic             grant_vld;
   logic [SELW-1:0]  scan_idx;
   logic [SELW-1:0]  grant_idx;
   logic [WIDTH-1:0] grant_data;
   logic [CH-1:0]    hi_req;
   logic [SELW-1:0]  hi_idx;
   logic [SELW-1:0]  lo_idx;

   assign slot_free = !out_valid || out_ready;

   // Out-of-range addr matches no channel, so it can never grant.
   always_comb begin
      dir_vld = 1'b0;
      for (int k = 0; k < CH; k++) begin
         if (addr == SELW'(k) && in_valid[k]) begin
            dir_vld = 1'b1;
         end
      end
   end

   // Round-robin: lowest requester at or above ptr, else wrap to lowest requester overall.
   always_comb begin
      hi_req = '0;
      hi_idx = '0;
      lo_idx = '0;
      for (int k = 0; k < CH; k++) begin
         hi_req[k] = in_valid[k] && (SELW'(k) >= ptr);
      end
      for (int k = CH - 1; k >= 0; k--) begin
         if (in_valid[k]) begin
            lo_idx = SELW'(k);
         end
         if (hi_req[k]) begin
            hi_idx = SELW'(k);
         end
      end
      scan_vld = |in_valid;
      scan_idx = (|hi_req) ? hi_idx : lo_idx;
   end

   assign grant_idx = mode ? scan_idx : addr;
   assign grant_vld = !rst && slot_free && (mode ? scan_vld : dir_vld);
   assign ptr_next  = (grant_idx == SELW'(CH - 1)) ? '0 : grant_idx + SELW'(1);

   always_comb begin
      grant_data = '0;
      in_ready   = '0;
      for (int k = 0; k < CH; k++) begin
         if (grant_idx == SELW'(k)) begin
            grant_data  = in_data[k*WIDTH +: WIDTH];
            in_ready[k] = grant_vld;
         end
      end
   end

   // A new grant always wins over draining, which gives 1 word/clk when out_ready stays high.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_data  <= '0;
         out_ch    <= '0;
         out_valid <= 1'b0;
         ptr       <= '0;
      end else if (grant_vld) begin
         out_data  <= grant_data;
         out_ch    <= grant_idx;
         out_valid <= 1'b1;
         if (mode) begin
            ptr <= ptr_next;
         end
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mux_n_arb.sv
// Testbench for mux_n_arb: scoreboarded grant/handshake model plus directed scenario checks,
// with a second CH=6 instance for the out-of-range address case.
module tb_mux_n_arb;
   localparam int WIDTH = 8;
   localparam int CH    = 8;
   localparam int SELW  = 3;
   localparam int CH6   = 6;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                rst;
   logic                mode;
   logic [SELW-1:0]     addr;
   logic [CH*WIDTH-1:0] in_data;
   logic [CH-1:0]       in_valid;
   logic [CH-1:0]       in_ready;
   logic [WIDTH-1:0]    out_data;
   logic [SELW-1:0]     out_ch;
   logic                out_valid;
   logic                out_ready;

   logic                 mode6;
   logic [SELW-1:0]      addr6;
   logic [CH6*WIDTH-1:0] in_data6;
   logic [CH6-1:0]       in_valid6;
   logic [CH6-1:0]       in_ready6;
   logic [WIDTH-1:0]     out_data6;
   logic [SELW-1:0]      out_ch6;
   logic                 out_valid6;
   logic                 out_ready6;

   mux_n_arb #(.WIDTH(WIDTH), .CH(CH), .SELW(SELW)) dut (
      .clk(clk), .rst(rst), .mode(mode), .addr(addr), .in_data(in_data),
      .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data), .out_ch(out_ch),
      .out_valid(out_valid), .out_ready(out_ready)
   );

   mux_n_arb #(.WIDTH(WIDTH), .CH(CH6), .SELW(SELW)) dut6 (
      .clk(clk), .rst(rst), .mode(mode6), .addr(addr6), .in_data(in_data6),
      .in_valid(in_valid6), .in_ready(in_ready6), .out_data(out_data6), .out_ch(out_ch6),
      .out_valid(out_valid6), .out_ready(out_ready6)
   );

   typedef struct {
      int               ch;
      logic [WIDTH-1:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   checks  = 0;
   int   errors  = 0;
   logic m_valid = 1'b0;
   logic m_known = 1'b0;
   int   m_ptr   = 0;

   function automatic void model_grant(output logic vld, output int g);
      vld = 1'b0;
      g   = 0;
      if (rst || (m_valid && !out_ready)) return;
      if (!mode) begin
         if (int'(addr) < CH && in_valid[addr]) begin
            vld = 1'b1;
            g   = int'(addr);
         end
      end else begin
         for (int i = 0; i < CH; i++) begin
            int j = (m_ptr + i) % CH;
            if (!vld && in_valid[j]) begin
               vld = 1'b1;
               g   = j;
            end
         end
      end
   endfunction

   // One clock: check in_ready and the held word on the falling edge, then advance the model.
   task automatic step();
      logic          gv;
      int            g;
      logic [CH-1:0] exp_rdy;
      exp_t          e;
      @(negedge clk);
      model_grant(gv, g);
      exp_rdy = '0;
      if (gv) exp_rdy[g] = 1'b1;
      checks++;
      if (in_ready !== exp_rdy) begin
         errors++;
         $display("FAIL in_ready: got %h expected %h", in_ready, exp_rdy);
      end
      if (m_known) begin
         checks++;
         if (out_valid !== m_valid) begin
            errors++;
            $display("FAIL out_valid: got %b expected %b", out_valid, m_valid);
         end
         if (m_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL scoreboard: got empty queue expected a held word");
            end else begin
               if (out_data !== exp_q[0].data || out_ch !== SELW'(exp_q[0].ch)) begin
                  errors++;
                  $display("FAIL out_word: got ch %0d data %h expected ch %0d data %h",
                           out_ch, out_data, exp_q[0].ch, exp_q[0].data);
               end
               if (out_ready && !rst) void'(exp_q.pop_front());
            end
         end
      end
      if (gv) begin
         e.ch   = g;
         e.data = in_data[g*WIDTH +: WIDTH];
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
      if (rst) begin
         m_valid = 1'b0;
         m_ptr   = 0;
         m_known = 1'b1;
         exp_q.delete();
      end else if (gv) begin
         m_valid = 1'b1;
         if (mode) m_ptr = (g == CH - 1) ? 0 : g + 1;
      end else if (out_ready) begin
         m_valid = 1'b0;
      end
   endtask

   task automatic check_out(input string name, input logic [SELW-1:0] ch,
                            input logic [WIDTH-1:0] data);
      checks++;
      if (out_valid !== 1'b1 || out_ch !== ch || out_data !== data) begin
         errors++;
         $display("FAIL %s: got v=%b ch=%0d data=%h expected v=1 ch=%0d data=%h",
                  name, out_valid, out_ch, out_data, ch, data);
      end
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      mode      = 1'b0;
      addr      = '0;
      in_valid  = 8'hFF;
      out_ready = 1'b1;
      for (int c = 0; c < 2; c++) begin
         step();
         checks++;
         if (out_valid !== 1'b0 || out_data !== '0 || out_ch !== '0) begin
            errors++;
            $display("FAIL reset_out: got v=%b ch=%0d data=%h expected v=0 ch=0 data=00",
                     out_valid, out_ch, out_data);
         end
         checks++;
         if (in_ready !== '0) begin
            errors++;
            $display("FAIL reset_in_ready: got %h expected 00", in_ready);
         end
      end
      checks++;
      if (out_valid6 !== 1'b0) begin
         errors++;
         $display("FAIL reset_ch6: got out_valid %b expected 0", out_valid6);
      end
      rst      = 1'b0;
      in_valid = '0;
   endtask

   task automatic test_direct();
      mode     = 1'b0;
      addr     = 3'd5;
      in_valid = 8'h20;
      #1;
      checks++;
      if (in_ready !== 8'h20) begin
         errors++;
         $display("FAIL direct_in_ready: got %h expected 20", in_ready);
      end
      step();
      check_out("direct_word", 3'd5, 8'hA5);
   endtask

   task automatic test_direct_empty();
      addr      = 3'd5;
      in_valid  = 8'hDF;
      addr6     = 3'd7;
      in_valid6 = 6'h3F;
      #1;
      checks++;
      if (in_ready !== '0 || in_ready6 !== '0) begin
         errors++;
         $display("FAIL direct_empty_ready: got %h/%h expected 00/00", in_ready, in_ready6);
      end
      step();
      checks++;
      if (out_valid !== 1'b0 || out_valid6 !== 1'b0) begin
         errors++;
         $display("FAIL direct_empty_valid: got %b/%b expected 0/0", out_valid, out_valid6);
      end
      addr6 = 3'd5;
      #1;
      checks++;
      if (in_ready6 !== 6'h20) begin
         errors++;
         $display("FAIL ch6_in_range_ready: got %h expected 20", in_ready6);
      end
      step();
      checks++;
      if (out_valid6 !== 1'b1 || out_ch6 !== 3'd5 || out_data6 !== 8'h65) begin
         errors++;
         $display("FAIL ch6_word: got v=%b ch=%0d data=%h expected v=1 ch=5 data=65",
                  out_valid6, out_ch6, out_data6);
      end
      in_valid6 = '0;
   endtask

   task automatic test_scan();
      int seq [5] = '{0, 3, 7, 0, 3};
      mode     = 1'b1;
      in_valid = 8'h89;
      for (int i = 0; i < 5; i++) begin
         step();
         check_out("scan_seq", SELW'(seq[i]), 8'hA0 + WIDTH'(seq[i]));
      end
   endtask

   task automatic test_reset_mid();
      rst = 1'b1;
      step();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_valid: got %b expected 0", out_valid);
      end
      rst = 1'b0;
      step();
      check_out("after_reset_grant", 3'd0, 8'hA0);
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (in_ready !== '0) begin
            errors++;
            $display("FAIL stall_in_ready: got %h expected 00", in_ready);
         end
         step();
         check_out("stall_hold", 3'd0, 8'hA0);
      end
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 8'h08) begin
         errors++;
         $display("FAIL release_in_ready: got %h expected 08", in_ready);
      end
      step();
      check_out("release_word", 3'd3, 8'hA3);
   endtask

   task automatic test_back_to_back();
      int addrs [4] = '{1, 6, 2, 4};
      mode     = 1'b0;
      in_valid = 8'hFF;
      for (int i = 0; i < 4; i++) begin
         addr = SELW'(addrs[i]);
         step();
         check_out("b2b_direct", SELW'(addrs[i]), 8'hA0 + WIDTH'(addrs[i]));
      end
      mode = 1'b1;
      step();
      check_out("ptr_kept_by_direct", 3'd4, 8'hA4);
      in_valid = '0;
      step();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL drain_valid: got %b expected 0", out_valid);
      end
   endtask

   initial begin
      for (int k = 0; k < CH; k++)  in_data[k*WIDTH +: WIDTH]  = 8'hA0 + WIDTH'(k);
      for (int k = 0; k < CH6; k++) in_data6[k*WIDTH +: WIDTH] = 8'h60 + WIDTH'(k);
      mode6      = 1'b0;
      addr6      = '0;
      in_valid6  = '0;
      out_ready6 = 1'b1;
      test_reset();
      test_direct();
      test_direct_empty();
      test_scan();
      test_reset_mid();
      test_backpressure();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
